// File: rtl/tfl_sensor_req.sv
// Traffic-light loop-detector front end: sync, debounce, waiting-vehicle counts.
// Ports: clk, reset (async, active-high), det_a/det_b raw detectors,
//   light_a/light_b lamp vectors {red,yellow,green}, sa/sb lane-busy flags,
//   cnt_a/cnt_b waiting counts, err sticky lamp-conflict flag.
// Build option: define TFL_SENSOR_ERR_EN to include the lamp checker driving err.

module tfl_sensor_lane #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             green,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [8:0] DB = 9'(DEBOUNCE);

  logic             sync1;
  logic             s;
  logic             filt;
  logic             filt_d;
  logic [7:0]       dcnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             rise;
  logic             fall;

  // filt_d trails filt by one cycle so a filt change is seen as an edge
  // exactly once, on the cycle after it happens.
  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    cnt_nx = cnt;
    if (rise && !green && cnt != '1)
      cnt_nx = cnt + 1'b1;
    else if (fall && green && cnt != '0)
      cnt_nx = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      dcnt   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else begin
      sync1  <= det;
      s      <= sync1;
      filt_d <= filt;
      if (s == filt) begin
        dcnt <= '0;
      end else if ({1'b0, dcnt} + 9'd1 == DB) begin
        filt <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
      cnt  <= cnt_nx;
      busy <= (cnt_nx != '0);
    end
  end

endmodule

module tfl_sensor_req #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_a,
  input  logic             det_b,
  input  logic [2:0]       light_a,
  input  logic [2:0]       light_b,
  output logic             sa,
  output logic             sb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             err
);

  tfl_sensor_lane #(
    .DEBOUNCE(DEBOUNCE),
    .CNT_W   (CNT_W)
  ) u_lane_a (
    .clk  (clk),
    .reset(reset),
    .det  (det_a),
    .green(light_a[0]),
    .cnt  (cnt_a),
    .busy (sa)
  );

  tfl_sensor_lane #(
    .DEBOUNCE(DEBOUNCE),
    .CNT_W   (CNT_W)
  ) u_lane_b (
    .clk  (clk),
    .reset(reset),
    .det  (det_b),
    .green(light_b[0]),
    .cnt  (cnt_b),
    .busy (sb)
  );

`ifdef TFL_SENSOR_ERR_EN
  logic lamp_bad;

  // Both lamp vectors must be one-hot and at least one road must show red.
  always_comb begin
    lamp_bad = !$onehot(light_a) || !$onehot(light_b)
            || !(light_a[2] || light_b[2]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (lamp_bad)
      err <= 1'b1;
  end
`else
  logic unused_lamp;

  assign err         = 1'b0;
  assign unused_lamp = ^{light_a[2:1], light_b[2:1]};
`endif

endmodule

// File: tb/tb_tfl_sensor_req.sv
// Bench for tfl_sensor_req: directed scenarios plus randomized detector
// traffic compared against a run-length reference model.

module tb_tfl_sensor_req;

  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef TFL_SENSOR_ERR_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          det_a;
  logic          det_b;
  logic [2:0]    light_a;
  logic [2:0]    light_b;
  logic          sa;
  logic          sb;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          err;

  int checks = 0;
  int fails  = 0;

  tfl_sensor_req #(
    .DEBOUNCE(D),
    .CNT_W   (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .det_a  (det_a),
    .det_b  (det_b),
    .light_a(light_a),
    .light_b(light_b),
    .sa     (sa),
    .sb     (sb),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. A lane's filtered level flips when the D most recent
  // synced samples all disagree with it; synced sample = raw sample of the
  // previous edge. A flip is counted on the following edge against the
  // green bit seen there.
  bit mr1   [2];
  bit mfilt [2];
  bit mpend [2];
  int mcnt  [2];
  bit sq_a  [$];
  bit sq_b  [$];

  function automatic bit all_differ(input bit q[$], input bit f);
    if (q.size() < D) return 1'b0;
    for (int i = q.size() - D; i < q.size(); i++)
      if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        mr1[l] = 0; mfilt[l] = 0; mpend[l] = 0; mcnt[l] = 0;
      end
      sq_a.delete();
      sq_b.delete();
    end else begin
      for (int l = 0; l < 2; l++) begin
        bit g, dv, flip;
        g    = (l == 0) ? light_a[0] : light_b[0];
        dv   = (l == 0) ? det_a : det_b;
        flip = (l == 0) ? all_differ(sq_a, mfilt[0])
                        : all_differ(sq_b, mfilt[1]);
        if (mpend[l]) begin
          if (mfilt[l] && !g && mcnt[l] < CMAX) mcnt[l]++;
          else if (!mfilt[l] && g && mcnt[l] > 0) mcnt[l]--;
        end
        mpend[l] = flip;
        if (flip) mfilt[l] = !mfilt[l];
        if (l == 0) begin
          sq_a.push_back(mr1[0]);
          if (sq_a.size() > 64) void'(sq_a.pop_front());
        end else begin
          sq_b.push_back(mr1[1]);
          if (sq_b.size() > 64) void'(sq_b.pop_front());
        end
        mr1[l] = dv;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 0; det_a = 0; det_b = 0;
    light_a = 3'b100; light_b = 3'b100;
    #1 reset = 1;
    #1;
    checks++;
    if ({sa, sb, cnt_a, cnt_b, err} !== '0) begin
      fails++;
      $display("FAIL reset_state got sa=%b sb=%b ca=%0d cb=%0d err=%b want 0",
               sa, sb, cnt_a, cnt_b, err);
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_latency();
    light_a = 3'b100;
    @(negedge clk);
    det_a = 1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      checks++;
      if (cnt_a !== ((e >= 6) ? 4'd1 : 4'd0) || sa !== (e >= 6)
          || cnt_a !== CW'(mcnt[0])) begin
        fails++;
        $display("FAIL latency edge%0d got cnt_a=%0d sa=%b want %0d",
                 e, cnt_a, sa, (e >= 6) ? 1 : 0);
      end
    end
    det_a = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (cnt_a !== 4'd1 || cnt_a !== CW'(mcnt[0])) begin
      fails++;
      $display("FAIL red_departure got cnt_a=%0d want 1", cnt_a);
    end
  endtask

  task automatic test_glitch();
    det_b = 1;
    repeat (3) @(negedge clk);
    det_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (cnt_b !== 4'd0 || sb !== 1'b0 || mcnt[1] != 0) begin
        fails++;
        $display("FAIL glitch cyc%0d got cnt_b=%0d sb=%b model=%0d want 0",
                 i, cnt_b, sb, mcnt[1]);
      end
    end
  endtask

  task automatic test_saturate();
    light_b = 3'b100;
    for (int ph = 0; ph < 2; ph++) begin
      for (int p = 0; p < 20; p++) begin
        det_b = 1;
        repeat (6) @(negedge clk);
        det_b = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (cnt_b !== CW'(mcnt[1]) || sb !== (mcnt[1] != 0)) begin
          fails++;
          $display("FAIL sat_model ph%0d p%0d got cnt_b=%0d sb=%b want %0d",
                   ph, p, cnt_b, sb, mcnt[1]);
        end
      end
      repeat (4) @(negedge clk);
      checks++;
      if (ph == 0 && (cnt_b !== 4'd15 || sb !== 1'b1)) begin
        fails++;
        $display("FAIL saturate_hi got cnt_b=%0d sb=%b want 15 1", cnt_b, sb);
      end else if (ph == 1 && (cnt_b !== 4'd0 || sb !== 1'b0)) begin
        fails++;
        $display("FAIL saturate_lo got cnt_b=%0d sb=%b want 0 0", cnt_b, sb);
      end
      light_b = 3'b001;
    end
    light_b = 3'b100;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int ea, eb, a0, b0;
    light_a = 3'b100; light_b = 3'b100;
    a0 = int'(cnt_a); b0 = int'(cnt_b);
    ea = -1; eb = -1;
    det_a = 1; det_b = 1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (ea < 0 && int'(cnt_a) != a0) ea = e;
      if (eb < 0 && int'(cnt_b) != b0) eb = e;
    end
    checks++;
    if (ea != 6 || eb != 6 || int'(cnt_a) != a0 + 1 || int'(cnt_b) != b0 + 1) begin
      fails++;
      $display("FAIL simultaneous got edges a=%0d b=%0d cnt=%0d/%0d want 6 6 %0d/%0d",
               ea, eb, cnt_a, cnt_b, a0 + 1, b0 + 1);
    end
    det_a = 0; det_b = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_err();
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_idle got %b want 0", err);
    end
    light_a = 3'b001; light_b = 3'b010;
    @(negedge clk);
    light_a = 3'b100; light_b = 3'b100;
    checks++;
    if (err !== EXP_ERR) begin
      fails++;
      $display("FAIL err_set got %b want %b", err, EXP_ERR);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== EXP_ERR) begin
      fails++;
      $display("FAIL err_sticky got %b want %b", err, EXP_ERR);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    @(negedge clk);
    reset = 0;
    light_a = 3'b100;
    repeat (3) begin
      det_a = 1;
      repeat (6) @(negedge clk);
      det_a = 0;
      repeat (6) @(negedge clk);
    end
    checks++;
    if (cnt_a !== 4'd3 || sa !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset got cnt_a=%0d sa=%b want 3 1", cnt_a, sa);
    end
    det_a = 1;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({sa, sb, cnt_a, cnt_b, err} !== '0) begin
      fails++;
      $display("FAIL mid_reset got sa=%b sb=%b ca=%0d cb=%0d err=%b want 0",
               sa, sb, cnt_a, cnt_b, err);
    end
    @(negedge clk);
    reset = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      checks++;
      if (cnt_a !== ((e >= 6) ? 4'd1 : 4'd0) || sa !== (e >= 6)
          || cnt_a !== CW'(mcnt[0])) begin
        fails++;
        $display("FAIL post_reset edge%0d got cnt_a=%0d sa=%b want %0d",
                 e, cnt_a, sa, (e >= 6) ? 1 : 0);
      end
    end
    det_a = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int la, lb, lt;
    la = 1; lb = 1; lt = 1;
    for (int c = 0; c < 1500; c++) begin
      if (--la == 0) begin det_a = ~det_a; la = $urandom_range(1, 9); end
      if (--lb == 0) begin det_b = ~det_b; lb = $urandom_range(1, 9); end
      if (--lt == 0) begin
        case ($urandom_range(0, 2))
          0: begin light_a = 3'b001; light_b = 3'b100; end
          1: begin light_a = 3'b100; light_b = 3'b001; end
          default: begin light_a = 3'b100; light_b = 3'b100; end
        endcase
        lt = $urandom_range(10, 60);
      end
      @(negedge clk);
      checks++;
      if (cnt_a !== CW'(mcnt[0]) || sa !== (mcnt[0] != 0)
          || cnt_b !== CW'(mcnt[1]) || sb !== (mcnt[1] != 0)) begin
        fails++;
        $display("FAIL random cyc%0d got a=%0d/%b b=%0d/%b want a=%0d b=%0d",
                 c, cnt_a, sa, cnt_b, sb, mcnt[0], mcnt[1]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL random_err got %b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_saturate();
    test_simultaneous();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tfl_sensor_req.md
TFL_SENSOR_REQ -- requirements
Module: tfl_sensor_req

Interface
REQ-001 Parameter: DEBOUNCE, default 4, number of consecutive synchronized cycles a detector level must differ from its filtered level before the filtered level changes (legal range 1..255).
REQ-002 Parameter: CNT_W, default 4, width of each lane's waiting-vehicle counter.
REQ-003 clk  input  1  clock, all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 det_a  input  1  raw loop detector, road A, asynchronous to clk, high = vehicle over loop.
REQ-006 det_b  input  1  raw loop detector, road B, same semantics.
REQ-007 light_a  input  3  road A lamp vector from the light controller: bit0 green, bit1 yellow, bit2 red.
REQ-008 light_b  input  3  road B lamp vector, same encoding.
REQ-009 sa  output  1  road A has at least one waiting vehicle, registered.
REQ-010 sb  output  1  road B has at least one waiting vehicle, registered.
REQ-011 cnt_a  output  CNT_W  road A waiting-vehicle count, registered.
REQ-012 cnt_b  output  CNT_W  road B waiting-vehicle count, registered.
REQ-013 err  output  1  sticky lamp-conflict flag, registered.

Function
REQ-014 Each detector SHALL pass through a 2-flop synchronizer; the second flop output is the synced level s.
REQ-015 Each lane SHALL hold a filtered level filt and an 8-bit debounce counter; the counter is cleared on any cycle where s equals filt.
REQ-016 When s differs from filt, the counter SHALL increment; on the edge where it would reach DEBOUNCE, filt SHALL take the value of s and the counter SHALL clear.
REQ-017 An s excursion shorter than DEBOUNCE cycles SHALL leave filt unchanged.
REQ-018 A filt 0->1 edge while the lane's green bit is 0 SHALL increment that lane's counter, saturating at 2^CNT_W-1.
REQ-019 A filt 1->0 edge while the lane's green bit is 1 SHALL decrement that lane's counter, saturating at 0.
REQ-020 A filt edge not covered by REQ-018 or REQ-019 SHALL leave the counter unchanged.
REQ-021 sa SHALL be registered as (next cnt_a != 0); sb SHALL be registered as (next cnt_b != 0); both change on the same edge as their counters.
REQ-022 Latency: a raw level change first sampled at edge 0 SHALL update s at edge 1, filt at edge 1+DEBOUNCE, and cnt/sa at edge 2+DEBOUNCE.
REQ-023 Lanes A and B SHALL be fully independent; simultaneous events on both lanes are each processed in the same cycle.
REQ-024 Lamp check: a cycle where light_a or light_b is not one-hot, or where neither light_a[2] nor light_b[2] is set, SHALL set err at the next edge.
REQ-025 Once set, err SHALL remain 1 until reset.

Reset
REQ-026 Asserting reset SHALL immediately clear the synchronizers, filt, debounce counters, cnt_a, cnt_b, sa, sb and err to 0.
REQ-027 Reset asserted mid-debounce or mid-count SHALL discard all pending state; after release, a detector held high SHALL be treated as a new arrival after the full REQ-022 latency.

Configuration
REQ-028 Macro TFL_SENSOR_ERR_EN: when defined, the REQ-024/025 lamp checker SHALL be built.
REQ-029 When TFL_SENSOR_ERR_EN is undefined, err SHALL be tied to constant 0, no checker logic SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-030 DEBOUNCE=4, light_a=100: det_a rises and stays high; sampled at edge 0 -> cnt_a=1 and sa=1 at edge 6.
REQ-031 det_a high for 3 synced cycles, then low -> filt_a, cnt_a and sa remain 0.
REQ-032 CNT_W=4, light_b=100: 20 clean det_b pulses -> cnt_b saturates at 15 with sb=1; then light_b=001 with 20 departures -> cnt_b=0 and sb=0, with no underflow.
REQ-033 Arrivals on both lanes on the same cycle -> cnt_a and cnt_b increment on the same edge.
REQ-034 light_a=001 and light_b=010 for one cycle -> err=1 at the next edge and held; with the macro undefined, err=0.
REQ-035 Assert reset mid-debounce with cnt_a=3 -> all outputs 0 immediately; after release with det_a still high, cnt_a=1 after 2+DEBOUNCE edges.
